// File: rtl/relay_credit_sender.sv
// relay_credit_sender: drains an FWFT source onto a LEVEL-stage registered link,
// gated by a credit counter replenished through a LEVEL-stage credit-return pipeline.
module relay_credit_sender #(
  parameter int DATA_WIDTH   = 32,
  parameter int LEVEL        = 2,
  parameter int CREDITS      = 8,
  parameter int CREDIT_WIDTH = $clog2(CREDITS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    src_empty_n,
  output logic                    src_read,
  input  logic [DATA_WIDTH-1:0]   src_dout,
  input  logic                    send_ce,
  output logic                    link_write,
  output logic [DATA_WIDTH-1:0]   link_din,
  input  logic                    link_credit,
  output logic [CREDIT_WIDTH-1:0] credits,
  output logic                    idle,
  output logic                    credit_err
);
  localparam logic [CREDIT_WIDTH-1:0] FULL = CREDIT_WIDTH'(CREDITS);
  logic [CREDIT_WIDTH-1:0] r_credits;
  logic r_idle, r_err;
  logic w_send, w_cred_d, w_busy, w_full, w_ovf;
  assign w_send = ~reset & src_empty_n & send_ce & (r_credits != '0);
  assign w_full = r_credits == FULL;
  assign w_ovf = w_full & w_cred_d & ~w_send;
  generate
    if (LEVEL == 0) begin : g_pass
      assign link_write = w_send;
      assign link_din = src_dout;
      assign w_cred_d = link_credit;
      assign w_busy = 1'b0;
    end else begin : g_pipe
      logic [LEVEL-1:0] r_fv, r_cv;
      logic [DATA_WIDTH-1:0] r_fd [LEVEL];
      always_ff @(posedge clk)
        if (reset) begin
          r_fv <= '0;
          r_cv <= '0;
        end else begin
          r_fv <= LEVEL'({r_fv, w_send});
          r_cv <= LEVEL'({r_cv, link_credit});
        end
      // payload stages are unreset; the valid bits alone qualify them
      always_ff @(posedge clk) begin
        r_fd[0] <= src_dout;
        for (int k = 1; k < LEVEL; k++) r_fd[k] <= r_fd[k-1];
      end
      assign link_write = r_fv[LEVEL-1];
      assign link_din = r_fd[LEVEL-1];
      assign w_cred_d = r_cv[LEVEL-1];
      assign w_busy = |r_fv | |r_cv;
    end
  endgenerate
  always_ff @(posedge clk)
    if (reset) begin
      r_credits <= FULL;
      r_err <= 1'b0;
      r_idle <= 1'b1;
    end else begin
      r_credits <= w_ovf ? FULL : r_credits - CREDIT_WIDTH'(w_send) + CREDIT_WIDTH'(w_cred_d);
      r_err <= r_err | w_ovf;
      r_idle <= w_full & ~w_send & ~w_busy;
    end
  assign src_read = w_send;
  assign credits = r_credits;
  assign idle = r_idle;
  assign credit_err = r_err;
endmodule

// File: doc/relay_credit_sender.md
# relay_credit_sender

Producer-side endpoint of a pipelined inter-slot stream link, the transmitter counterpart of the almost-full receiving FIFO. It drains a first-word fall-through (FWFT) source, launches words across LEVEL register stages, and enforces flow control with a credit counter. Credits are returned by the receiver, one pulse per word it pops, and travel back through LEVEL register stages. Because of this, the receiver needs no grace-period headroom and the link carries no combinational path in either direction.

## Interface
Parameters:
- DATA_WIDTH, 32, payload width.
- LEVEL, 2, register stages on the forward path; the same count applies to the credit-return path. Range 0..8.
- CREDITS, 8, receiver buffer depth and the initial credit count. Range 1..1024.
- CREDIT_WIDTH, $clog2(CREDITS+1), width of the credit counter.

Ports:
- clk, in, 1, single clock.
- reset, in, 1, synchronous, active-high.
- src_empty_n, in, 1, FWFT source has data.
- src_read, out, 1, pop strobe to the source.
- src_dout, in, DATA_WIDTH, FWFT source head word.
- send_ce, in, 1, send enable; when low, src_read is held low.
- link_write, out, 1, word valid on the link; asserted for one cycle per word.
- link_din, out, DATA_WIDTH, link payload.
- link_credit, in, 1, credit pulse from the receiver, one per pop.
- credits, out, CREDIT_WIDTH, current credit count (registered).
- idle, out, 1, high when credits == CREDITS and no word is in flight on either pipeline.
- credit_err, out, 1, sticky flag for credit overflow.

## Operation
- Send condition: send = src_empty_n & send_ce & (credits != 0).
- src_read = send. This is combinational from inputs and registered state only; it never depends on link_credit in the same cycle.
- Forward pipeline:
  - Stage 0 captures {send, src_dout} every cycle.
  - Stage k captures stage k-1.
  - link_write and link_din come from stage LEVEL-1.
  - Data registers carry no reset; only the valid bits reset.
- Credit pipeline: link_credit passes through LEVEL registers, giving cred_d.
- Credit counter update: credits <= credits - send + cred_d.
  - Send and credit in the same cycle leave the count unchanged.
  - No bypass: when credits == 0, a cred_d arriving that cycle enables a send only on the next cycle.
- Overflow:
  - Overflow occurs when credits == CREDITS, cred_d = 1, and send = 0.
  - On overflow, credits holds at CREDITS and credit_err is set.
  - credit_err clears only on reset.
- Underflow is impossible by construction, since a send requires credits != 0.
- LEVEL == 0 (passthrough):
  - link_write = send and link_din = src_dout, both combinational.
  - cred_d = link_credit.
  - The counter behaves as above.
- Reset (at any time):
  - Forward and credit valid bits clear, so in-flight words and credits are dropped.
  - credits <= CREDITS, credit_err <= 0.
  - The receiver shares the same reset; partial reset of the link is unsupported.

## Timing
- Reset values: src_read is 0 while reset is high; link_write = 0, credits = CREDITS, idle = 1, credit_err = 0.
- Forward latency: a word popped from the source in cycle t appears on link_write/link_din in cycle t+LEVEL (LEVEL ≥ 1).
- Credit latency: a link_credit pulse in cycle t is reflected in credits at cycle t+LEVEL+1, i.e. it affects send in cycle t+LEVEL+1.
- Throughput: one word per cycle while credits != 0.
- Sustained full rate requires CREDITS ≥ 2·LEVEL + receiver pop latency + 1.
- Back-to-back sends produce back-to-back link_write pulses with no bubbles inserted.
- idle is registered and goes high no earlier than one cycle after the last pipeline valid clears.

## Test plan
- Reset sweep: assert reset mid-burst with LEVEL=2 and CREDITS=8. Require link_write = 0 one cycle after reset rises, credits = 8, idle = 1 after the pipeline drains, and no stale word emitted after reset deasserts.
- Credit exhaustion: source always non-empty, no credits returned. Require exactly 8 src_read pulses in cycles 0..7, then src_read = 0. link_write pulses occur in cycles 2..9 with data in the same order; credits reads 0.
- Credit return latency: with credits = 0, pulse link_credit at cycle t. Require credits = 1 at t+3 and src_read = 1 at t+3 (LEVEL=2), then 0 again.
- Simultaneous send and credit: steady stream with a credit returned every cycle. Require credits constant at its current value and one word per cycle indefinitely.
- Overflow: at idle, pulse link_credit once. Require credit_err = 1 at t+3, credits stays 8, and credit_err stays set until reset.
- LEVEL=0 passthrough: src_empty_n=1, send_ce=1. Require link_write = src_read in the same cycle and link_din = src_dout. After 8 sends, stall until a credit arrives; the resend occurs in the cycle after the credit.
